// File: rtl/vote_pkg.sv
// Shared constants and types for the vote collector: voter count, ballot width
// and the round-state encoding.
package vote_pkg;

  localparam int NUM_VOTERS = 4;
  localparam int BALLOT_W   = NUM_VOTERS;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } vote_state_t;

endpackage

// File: rtl/vote_edge.sv
// Rising-edge detector for one synchronous button level: flags a press when
// the input is 1 now and was 0 at the previous edge.
module vote_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;

  // The previous sample tracks the input in every state, so a held button
  // never looks like a fresh press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= d_i;
  end

  assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/vote_collector.sv
// Collects one yes/no vote per voter per round and presents the held ballot.
// A round closes when everyone has voted or the round timer runs out.
module vote_collector
  import vote_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                open,
  input  logic [BALLOT_W-1:0] yes,
  input  logic [BALLOT_W-1:0] no,
  output logic [BALLOT_W-1:0] ballot,
  output logic                ballot_valid,
  output logic [BALLOT_W-1:0] voted,
  output logic                busy,
  output logic                timed_out
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  // Timer value at the edge where it steps to TIMEOUT_CYCLES-1 and closes the round.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 2);

  vote_state_t         state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [BALLOT_W-1:0] voted_q, voted_d;
  logic [BALLOT_W-1:0] ballot_q, ballot_d;
  logic                timed_out_q, timed_out_d;
  logic [BALLOT_W-1:0] yes_rise, no_rise;

  for (genvar k = 0; k < NUM_VOTERS; k++) begin : g_edge
    vote_edge u_yes (.clk(clk), .rst(rst), .d_i(yes[k]), .rise_o(yes_rise[k]));
    vote_edge u_no  (.clk(clk), .rst(rst), .d_i(no[k]),  .rise_o(no_rise[k]));
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    voted_d     = voted_q;
    ballot_d    = ballot_q;
    timed_out_d = timed_out_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (open) begin
          state_d     = ST_COLLECT;
          timer_d     = '0;
          voted_d     = '0;
          ballot_d    = '0;
          timed_out_d = 1'b0;
        end
      end
      ST_COLLECT: begin
        timer_d = timer_q + 1'b1;
        // Simultaneous yes and no cancel each other; the voter may try again.
        for (int k = 0; k < NUM_VOTERS; k++) begin
          if (!voted_q[k] && (yes_rise[k] ^ no_rise[k])) begin
            voted_d[k]  = 1'b1;
            ballot_d[k] = yes_rise[k];
          end
        end
        if (&voted_d) begin
          state_d     = ST_DONE;
          timed_out_d = 1'b0;
        end else if (timer_q == TMO_LAST) begin
          state_d     = ST_DONE;
          timed_out_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      voted_q     <= '0;
      ballot_q    <= '0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      voted_q     <= voted_d;
      ballot_q    <= ballot_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign ballot       = ballot_q;
  assign voted        = voted_q;
  assign timed_out    = timed_out_q;
  assign busy         = (state_q == ST_COLLECT);
  assign ballot_valid = (state_q == ST_DONE);

endmodule

// File: tb/tb_vote_collector.sv
// Directed bench for vote_collector with an 8-cycle round timeout.
module tb_vote_collector;

  logic       clk;
  logic       rst;
  logic       open;
  logic [3:0] yes;
  logic [3:0] no;
  logic [3:0] ballot;
  logic       ballot_valid;
  logic [3:0] voted;
  logic       busy;
  logic       timed_out;

  int checks   = 0;
  int failures = 0;

  vote_collector #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .open(open), .yes(yes), .no(no),
    .ballot(ballot), .ballot_valid(ballot_valid), .voted(voted),
    .busy(busy), .timed_out(timed_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic open_round();
    open = 1'b1;
    tick();
    open = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [3:0] b, input logic v,
                           input logic [3:0] vt, input logic bs, input logic t);
    check({tag, ".ballot"},       8'(ballot),       8'(b));
    check({tag, ".ballot_valid"}, 8'(ballot_valid), 8'(v));
    check({tag, ".voted"},        8'(voted),        8'(vt));
    check({tag, ".busy"},         8'(busy),         8'(bs));
    check({tag, ".timed_out"},    8'(timed_out),    8'(t));
  endtask

  initial begin
    rst = 1'b1; open = 1'b0; yes = '0; no = '0;
    #3;
    check_all("reset", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // Full round: yes, yes, no, yes on separate cycles.
    open_round();
    check_all("open1", 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
    yes = 4'b0001; tick(); yes = '0;
    check_all("v0", 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0);
    yes = 4'b0010; tick(); yes = '0;
    no  = 4'b0100; tick(); no  = '0;
    check_all("v2", 4'b0011, 1'b0, 4'b0111, 1'b1, 1'b0);
    yes = 4'b1000; tick(); yes = '0;
    check_all("done1", 4'b1011, 1'b1, 4'b1111, 1'b0, 1'b0);
    tick();
    no = 4'b1111; tick(); no = '0;
    check_all("done1_hold", 4'b1011, 1'b1, 4'b1111, 1'b0, 1'b0);

    // Timeout with two votes: DONE exactly 7 edges after open.
    open_round();
    yes = 4'b0011; tick(); yes = '0;
    repeat (5) tick();
    check_all("tmo_pre", 4'b0011, 1'b0, 4'b0011, 1'b1, 1'b0);
    tick();
    check_all("tmo", 4'b0011, 1'b1, 4'b0011, 1'b0, 1'b1);

    // Voter 2 changes mind (ignored); voter 3 presses both, then no.
    open_round();
    check("reopen.timed_out", 8'(timed_out), 8'h0);
    yes = 4'b1100; no = 4'b1000; tick(); yes = '0; no = '0;
    check_all("both", 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0);
    no = 4'b0100; tick(); no = '0;
    check_all("v2_relock", 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0);
    no = 4'b1000; tick(); no = '0;
    check_all("v3_no", 4'b0100, 1'b0, 4'b1100, 1'b1, 1'b0);
    yes = 4'b0011; tick(); yes = '0;
    check_all("done3", 4'b0111, 1'b1, 4'b1111, 1'b0, 1'b0);

    // yes[0] held across open never counts; round closes by timeout.
    yes = 4'b0001;
    tick();
    open_round();
    no = 4'b1110; tick(); no = '0;
    check_all("held_v", 4'b0000, 1'b0, 4'b1110, 1'b1, 1'b0);
    repeat (5) tick();
    check_all("held_pre", 4'b0000, 1'b0, 4'b1110, 1'b1, 1'b0);
    tick();
    check_all("held_tmo", 4'b0000, 1'b1, 4'b1110, 1'b0, 1'b1);
    yes = '0;
    tick();

    // Asynchronous reset mid-round.
    open_round();
    yes = 4'b0101; tick(); yes = '0;
    check_all("pre_rst", 4'b0101, 1'b0, 4'b0101, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_all("async_rst", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    #1 rst = 1'b0;
    tick();
    check_all("idle_after_rst", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    open_round();
    check_all("clean_open", 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
    repeat (6) tick();
    check("clean_pre.busy", 8'(busy), 8'h1);
    tick();
    check_all("clean_tmo", 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1);

    // open during COLLECT ignored; fourth vote lands on the timeout edge.
    open_round();
    yes = 4'b0001; tick(); yes = '0;
    open = 1'b1; tick(); open = 1'b0;
    check_all("open_ignored", 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0);
    no  = 4'b0010; tick(); no  = '0;
    yes = 4'b0100; tick(); yes = '0;
    tick(); tick();
    check_all("edge_pre", 4'b0101, 1'b0, 4'b0111, 1'b1, 1'b0);
    yes = 4'b1000; tick(); yes = '0;
    check_all("edge_done", 4'b1101, 1'b1, 4'b1111, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
